// File: rtl/spram_pkg.sv
// -----------------------------------------------------------------------------
// spram_pkg
// Shared constants for the single-port-RAM FIFO controller.
//   DEF_DATA_WIDTH : default word width (must match the attached RAM)
//   DEF_ADDR_WIDTH : default RAM address width
//   DEPTH          : RAM words for the default address width
//   CNT_W          : width of the total-occupancy count (RAM + in flight + buffer)
// -----------------------------------------------------------------------------
package spram_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;
    localparam int CNT_W          = DEF_ADDR_WIDTH + 2;
endpackage

// File: rtl/spram_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// spram_fifo_ctrl_if
// Bundles the write stream, read stream, occupancy count and RAM port of the
// FIFO controller.
//   slave  : controller view (accepts in_*, produces out_*, drives the RAM)
//   master : surrounding view (producer, consumer and the RAM itself)
// -----------------------------------------------------------------------------
interface spram_fifo_ctrl_if
    import spram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH+1:0] count;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  in_valid, in_data, out_ready, ram_dout,
        output in_ready, out_valid, out_data, count, ram_we, ram_addr, ram_din
    );

    modport master (
        output in_valid, in_data, out_ready, ram_dout,
        input  in_ready, out_valid, out_data, count, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/spram_out_buf.sv
// -----------------------------------------------------------------------------
// spram_out_buf
// Two-entry first-in first-out buffer that absorbs RAM read data so the
// consumer sees a registered head word.
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_data_i this cycle (caller guarantees room)
//   push_data_i  : word to store
//   pop_i        : drop the head word this cycle (caller guarantees cnt_o != 0)
//   head_o       : entry 0, the oldest word
//   cnt_o        : occupancy 0..2
// -----------------------------------------------------------------------------
module spram_out_buf
    import spram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [1:0]            cnt_o
);
    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]            cnt_q, cnt_d;

    // Next-state of the two entries and occupancy for each push/pop combination.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = push_data_i;
                end else begin
                    ent1_d = push_data_i;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged: the new word lands behind whatever remains.
                if (cnt_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = push_data_i;
                end else begin
                    ent0_d = push_data_i;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Buffer state register; reset discards any held words.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o = ent0_q;
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/spram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// spram_fifo_ctrl
// FIFO controller in front of a single-port RAM with a registered read port.
// One RAM operation per cycle; reads win over writes. A 2-entry output buffer
// hides the 1-cycle read latency so pops can run at 1 word/cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : in_* write stream, out_* read stream, count, and the RAM port
//              (ram_we/ram_addr/ram_din out, ram_dout in)
// -----------------------------------------------------------------------------
module spram_fifo_ctrl
    import spram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    spram_fifo_ctrl_if.slave  bus
);
    localparam int FIFO_DEPTH = 2 ** ADDR_WIDTH;
    localparam int COUNT_W    = ADDR_WIDTH + 2;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [COUNT_W-1:0]    count_q, count_d;

    logic [1:0]            buf_cnt_s;
    logic [DATA_WIDTH-1:0] buf_head_s;
    logic [2:0]            buf_after_s;
    logic                  out_valid_s;
    logic                  pop_s;
    logic                  rd_issue_s;
    logic                  in_ready_s;
    logic                  wr_s;

    // Issue/accept decisions and RAM port drive (combinational from out_ready/in_valid).
    always_comb begin
        out_valid_s = !rst && (buf_cnt_s != 2'd0);
        pop_s       = out_valid_s && bus.out_ready;
        // Buffer occupancy once the in-flight word lands and this cycle's pop leaves.
        buf_after_s = {1'b0, buf_cnt_s} + {2'b00, rd_pend_q} - {2'b00, pop_s};
        rd_issue_s  = !rst && (ram_cnt_q != '0) && (buf_after_s < 3'd2);
        in_ready_s  = !rst && (ram_cnt_q != (ADDR_WIDTH+1)'(FIFO_DEPTH)) && !rd_issue_s;
        wr_s        = bus.in_valid && in_ready_s;
    end

    // Pointer, RAM occupancy, in-flight flag and total count next-state.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        rd_pend_d = rd_issue_s;
        count_d   = count_q;
        if (rd_issue_s) begin
            rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
            ram_cnt_d = ram_cnt_q - (ADDR_WIDTH+1)'(1);
        end else if (wr_s) begin
            wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
            ram_cnt_d = ram_cnt_q + (ADDR_WIDTH+1)'(1);
        end else begin
            ram_cnt_d = ram_cnt_q;
        end
        // Total occupancy only moves on an accept or a pop; reads just relocate words.
        case ({wr_s, pop_s})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            count_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            rd_pend_q <= rd_pend_d;
            count_q   <= count_d;
        end
    end

    // ram_dout is only meaningful in the cycle after a read was issued.
    spram_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rd_pend_q),
        .push_data_i (bus.ram_dout),
        .pop_i       (pop_s),
        .head_o      (buf_head_s),
        .cnt_o       (buf_cnt_s)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = buf_head_s;
    assign bus.count     = count_q;
    assign bus.ram_we    = wr_s;
    assign bus.ram_addr  = wr_s ? wr_ptr_q : rd_ptr_q;
    assign bus.ram_din   = bus.in_data;
endmodule

// File: doc/spram_fifo_ctrl.md
# spram_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of a single-port RAM and drives its `we`/`addr`/`din` port while consuming its registered `dout`. It turns a valid/ready write stream and a valid/ready read stream into one RAM operation per cycle, because the RAM can either write or read in a cycle, never both. A 2-entry output buffer hides the RAM's 1-cycle read latency, so pops sustain 1 word/cycle when no writes compete.

## Interface
- `DATA_WIDTH`, 8, word width; must match the RAM.
- `ADDR_WIDTH`, 4, RAM address width; `DEPTH = 2**ADDR_WIDTH`.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  word accepted this cycle when `in_valid && in_ready`.
- `in_data`  in  DATA_WIDTH  write word.
- `out_valid`  out  1  head word available.
- `out_ready`  in  1  consumer takes the head when `out_valid && out_ready`.
- `out_data`  out  DATA_WIDTH  head word.
- `count`  out  ADDR_WIDTH+2  total words held (RAM + in-flight read + buffer), 0..DEPTH+2.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_WIDTH  RAM address.
- `ram_din`  out  DATA_WIDTH  RAM write data.
- `ram_dout`  in  DATA_WIDTH  RAM registered read data; it updates only on `we=0` cycles.

## Operation
- State: `wr_ptr` and `rd_ptr` (ADDR_WIDTH bits each, natural wrap DEPTH-1 -> 0), `ram_cnt` (ADDR_WIDTH+1 bits, 0..DEPTH), `rd_pend` (1 bit, a read was issued last cycle), and a 2-entry output buffer with occupancy `buf_cnt` (0..2).
- Read issue: `rd_issue = !rst && ram_cnt != 0 && (buf_cnt + rd_pend - pop) < 2`, where `pop = out_valid && out_ready`.
- Write: `in_ready = !rst && ram_cnt != DEPTH && !rd_issue`. Reads have priority over writes.
- RAM drive: on a read, `ram_we=0` and `ram_addr=rd_ptr`. On a write, `ram_we=1`, `ram_addr=wr_ptr`, `ram_din=in_data`. When idle, `ram_we=0` and `ram_addr=rd_ptr`. `ram_din` equals `in_data` at all times.
- A read increments `rd_ptr`, decrements `ram_cnt` and sets `rd_pend` for the next cycle. A write increments `wr_ptr` and `ram_cnt`.
- In the cycle where `rd_pend=1`, `ram_dout` is pushed into the output buffer.
- Output buffer is first-in first-out. `out_data` is entry 0 and `out_valid = buf_cnt != 0`. A push and a pop may happen in the same cycle.
- `count = ram_cnt + rd_pend + buf_cnt`, registered.
- Full: `ram_cnt == DEPTH` drops `in_ready`, even though the buffer may be holding up to 2 more words. Empty: `count == 0` gives `out_valid=0` with no read issued.
- Reset clears the pointers, `ram_cnt`, `rd_pend`, `buf_cnt` and `count` to 0. Buffered data is discarded, and a read in flight is dropped even if it lands in the cycle after reset. While `rst` is high, `in_ready=0`, `ram_we=0` and `out_valid=0`.

## Timing
- Combinational paths:
  - `out_ready` -> `rd_issue` -> `in_ready`, `ram_we`, `ram_addr`.
  - `in_valid`, `in_data` -> `ram_we`, `ram_din`.
- All other outputs are registered.
- Latency with the FIFO empty:
  - write accepted at cycle N
  - read issued at N+1
  - `ram_dout` valid at N+2, captured into the buffer at the end of N+2
  - `out_valid=1` at N+3
- Sustained pop rate is 1/cycle with no writes. When both sides run continuously, the throughput of pushes plus pops is 1 op/cycle total.
- `rd_pend` is cleared every cycle in which no read was issued on the previous cycle. The block never captures `ram_dout` on any other cycle.

## Structure
- Shared package `spram_pkg`: default `DATA_WIDTH`/`ADDR_WIDTH`, plus the derived `DEPTH` and `CNT_W = ADDR_WIDTH+2` constants.
- One natural sub-module: `spram_out_buf`, the 2-entry output FIFO with push/pop/occupancy.
- The RAM itself is instantiated by the parent next to this block, not inside it.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 with `out_ready=0`. Required: `ram_we` high with `ram_addr` 0, 1, 2 in turn; `out_valid` rises 3 cycles after the first accept; `count=3`.
- Fill with `out_ready=0` (DEPTH=16): `in_ready` drops after 18 accepts. 16 words stay in the RAM and 2 sit in the buffer; `count=18`. Draining returns 18 words in order.
- Continuous pop from a full FIFO with `in_valid=0`: `out_valid` stays high every cycle; data comes out in order; `rd_ptr` wraps 15 -> 0.
- Simultaneous `in_valid=1` and a pop that frees a slot: the read wins, `in_ready=0` and `ram_we=0` that cycle, and the write is accepted the next free cycle.
- Wrap-around: push and pop 40 words (incrementing 0x00..0x27) with random valid/ready. Required: no loss, no duplication, in-order output; `count` matches the model every cycle.
- Assert `rst` while `rd_pend=1` and `buf_cnt=2`. Required: the next cycle shows `out_valid=0` and `count=0`; stale `ram_dout` is never output; and a subsequent write is read back correctly from address 0.
